// File: rtl/ram_loader_ctrl.sv
// Program-load sequencer: while prog_en is high it freezes the CPU and writes host bytes
// into RAM addresses 0..15 via the shared bus, MAR/data strobes and a write pulse.
module ram_loader_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_en,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              n_load_addr,
    output logic              n_load_data,
    output logic              ram_we,
    output logic              cpu_run,
    output logic              cpu_rst_n,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_done
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    // Handshake: a byte transfers on the rising edge where in_valid and in_ready
    // are both high; in_ready is high only in S_WAIT, so nothing is buffered.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_FULL,
        S_RESTART,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        byte_q;
    logic [7:0]        byte_nx;
    logic [ADDR_W:0]   count_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            addr         <= '0;
            byte_q       <= '0;
            words_loaded <= '0;
        end else begin
            state        <= state_nx;
            addr         <= addr_nx;
            byte_q       <= byte_nx;
            words_loaded <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        byte_nx  = byte_q;
        count_nx = words_loaded;
        case (state)
            S_IDLE: begin
                if (prog_en) begin
                    state_nx = S_WAIT;
                    addr_nx  = '0;
                    count_nx = '0;
                end else begin
                    state_nx = S_RESTART;
                end
            end
            S_WAIT: begin
                // A byte offered together with prog_en falling is still written.
                if (in_valid) begin
                    byte_nx  = in_data;
                    state_nx = S_ADDR;
                end else if (!prog_en) begin
                    state_nx = S_RESTART;
                end
            end
            S_ADDR:  state_nx = S_DATA;
            S_DATA:  state_nx = S_WRITE;
            S_WRITE: begin
                addr_nx = addr + 1'b1;
                if (words_loaded != FULL_CNT) begin
                    count_nx = words_loaded + 1'b1;
                end
                if (words_loaded == LAST_CNT) begin
                    state_nx = S_FULL;
                end else if (!prog_en) begin
                    state_nx = S_RESTART;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_FULL: begin
                if (!prog_en) begin
                    state_nx = S_RESTART;
                end
            end
            S_RESTART: state_nx = S_RUN;
            S_RUN: begin
                if (prog_en) begin
                    state_nx = S_WAIT;
                    addr_nx  = '0;
                    count_nx = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // S_IDLE is only occupied directly after a reset edge, so holding the CPU in
    // reset there gives cpu_rst_n=0 during reset and exactly one RESTART cycle after.
    always_comb begin
        in_ready    = 1'b0;
        bus_out     = 8'h00;
        bus_oe      = 1'b0;
        n_load_addr = 1'b1;
        n_load_data = 1'b1;
        ram_we      = 1'b0;
        cpu_run     = 1'b0;
        cpu_rst_n   = 1'b1;
        load_done   = 1'b0;
        case (state)
            S_IDLE:  cpu_rst_n = 1'b0;
            S_WAIT:  in_ready  = 1'b1;
            S_ADDR: begin
                bus_oe      = 1'b1;
                bus_out     = 8'(addr);
                n_load_addr = 1'b0;
            end
            S_DATA: begin
                bus_oe      = 1'b1;
                bus_out     = byte_q;
                n_load_data = 1'b0;
            end
            S_WRITE:   ram_we    = 1'b1;
            S_FULL:    load_done = 1'b1;
            S_RESTART: cpu_rst_n = 1'b0;
            S_RUN:     cpu_run   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Directed bench for ram_loader_ctrl: reset, back-to-back loads, full memory,
// prog_en drop mid-write, reload from RUN and reset during ADDR.
module tb_ram_loader_ctrl;

    logic       clk;
    logic       rst_n;
    logic       prog_en;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       n_load_addr;
    logic       n_load_data;
    logic       ram_we;
    logic       cpu_run;
    logic       cpu_rst_n;
    logic [4:0] words_loaded;
    logic       load_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    int last_we  = -1;
    bit ff_seen  = 1'b0;

    ram_loader_ctrl #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_en      (prog_en),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .n_load_addr  (n_load_addr),
        .n_load_data  (n_load_data),
        .ram_we       (ram_we),
        .cpu_run      (cpu_run),
        .cpu_rst_n    (cpu_rst_n),
        .words_loaded (words_loaded),
        .load_done    (load_done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (bus_oe && bus_out == 8'hFF) ff_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Starts at a negedge in WAIT; returns at the negedge after WRITE.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] a, input bit b2b);
        in_data  = d;
        in_valid = 1'b1;
        check("wait_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("addr_bus_oe", bus_oe, 1);
        check("addr_bus_out", bus_out, a);
        check("addr_n_load_addr", n_load_addr, 0);
        check("addr_in_ready", in_ready, 0);
        @(negedge clk);
        check("data_bus_out", bus_out, d);
        check("data_n_load_data", n_load_data, 0);
        check("data_n_load_addr", n_load_addr, 1);
        @(negedge clk);
        check("write_ram_we", ram_we, 1);
        check("write_bus_oe", bus_oe, 0);
        if (b2b) check("we_spacing", 16'(cyc - last_we), 4);
        last_we = cyc;
        @(negedge clk);
        check("after_write_ram_we", ram_we, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        prog_en  = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_in_ready", in_ready, 0);
        check("rst_bus_oe", bus_oe, 0);
        check("rst_bus_out", bus_out, 8'h00);
        check("rst_n_load_addr", n_load_addr, 1);
        check("rst_n_load_data", n_load_data, 1);
        check("rst_ram_we", ram_we, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_words", words_loaded, 0);
        check("rst_load_done", load_done, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("restart_cpu_rst_n", cpu_rst_n, 0);
        check("restart_cpu_run", cpu_run, 0);
        @(negedge clk);
        check("run_cpu_rst_n", cpu_rst_n, 1);
        check("run_cpu_run", cpu_run, 1);
        @(negedge clk);
        check("run_hold_cpu_run", cpu_run, 1);
        check("run_hold_cpu_rst_n", cpu_rst_n, 1);

        // Enter load mode, three bytes back-to-back
        prog_en = 1'b1;
        @(negedge clk);
        check("load_cpu_run", cpu_run, 0);
        check("load_in_ready", in_ready, 1);
        check("load_words0", words_loaded, 0);
        send_byte(8'h1A, 8'h00, 1'b0);
        send_byte(8'h2B, 8'h01, 1'b1);
        send_byte(8'h3C, 8'h02, 1'b1);
        check("three_words", words_loaded, 3);

        // Leave load mode: RESTART next cycle, cpu_run the one after
        prog_en = 1'b0;
        @(negedge clk);
        check("exit_restart", cpu_rst_n, 0);
        check("exit_restart_run", cpu_run, 0);
        @(negedge clk);
        check("exit_run", cpu_run, 1);
        check("exit_words_held", words_loaded, 3);

        // Fill all 16 words, then offer 0xFF
        prog_en = 1'b1;
        @(negedge clk);
        check("fill_words0", words_loaded, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 8'(i), i != 0);
        check("full_load_done", load_done, 1);
        check("full_words", words_loaded, 16);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_in_ready", in_ready, 0);
            check("full_bus_oe", bus_oe, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full_still_done", load_done, 1);
        check("ff_never_on_bus", ff_seen, 0);
        prog_en = 1'b0;
        @(negedge clk);
        check("full_exit_restart", cpu_rst_n, 0);
        check("full_exit_done", load_done, 0);
        @(negedge clk);
        check("full_exit_run", cpu_run, 1);
        check("full_words_held", words_loaded, 16);

        // Reload from RUN: address restarts at 0
        prog_en = 1'b1;
        @(negedge clk);
        check("reload_cpu_run", cpu_run, 0);
        check("reload_in_ready", in_ready, 1);
        send_byte(8'h99, 8'h00, 1'b0);
        check("reload_words", words_loaded, 1);
        send_byte(8'h44, 8'h01, 1'b1);

        // Drop prog_en during DATA of 0x55 at address 2
        in_data  = 8'h55;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("drop_addr_bus", bus_out, 8'h02);
        @(negedge clk);
        check("drop_data_bus", bus_out, 8'h55);
        prog_en = 1'b0;
        @(negedge clk);
        check("drop_write_we", ram_we, 1);
        @(negedge clk);
        check("drop_restart", cpu_rst_n, 0);
        check("drop_restart_words", words_loaded, 3);
        @(negedge clk);
        check("drop_run_2cyc", cpu_run, 1);

        // Reset during ADDR aborts the write
        prog_en = 1'b1;
        @(negedge clk);
        in_data  = 8'h77;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstw_addr_phase", n_load_addr, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstw_bus_oe", bus_oe, 0);
        check("rstw_n_load_addr", n_load_addr, 1);
        check("rstw_words", words_loaded, 0);
        check("rstw_ram_we", ram_we, 0);
        prog_en = 1'b0;
        @(negedge clk);
        check("rstw_ram_we2", ram_we, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstw_run", cpu_run, 1);

        // 3 + 16 + 1 + 1 + 1 pulses, none from the aborted write
        check("we_pulse_total", 16'(we_cnt), 22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
